// File: rtl/fp_align_unpack.sv
// FPU add/sub front end: unpacks two single-precision operands, orders them by magnitude and
// aligns the smaller mantissa to the larger exponent with guard/round/sticky, over two pipeline stages.
module fp_align_unpack #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [EXP_W+FRAC_W:0]     in_a,
    input  logic [EXP_W+FRAC_W:0]     in_b,
    input  logic                      in_op,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [FRAC_W+4:0]         out_mant_l,
    output logic [FRAC_W+4:0]         out_mant_s,
    output logic [EXP_W-1:0]          out_exp,
    output logic                      out_sign,
    output logic                      out_eff_sub,
    output logic                      out_swapped,
    output logic                      out_nan,
    output logic                      out_inf
);

    localparam int W       = EXP_W + FRAC_W + 1;
    localparam int MW      = FRAC_W + 5;
    localparam int SH_BITS = $clog2(MW);

    localparam logic [EXP_W-1:0] EXP_ONE = {{(EXP_W-1){1'b0}}, 1'b1};

    // operand fields
    logic                sign_a;
    logic                sign_b_eff;
    logic [EXP_W-1:0]    exp_a;
    logic [EXP_W-1:0]    exp_b;
    logic [EXP_W-1:0]    exp_a_eff;
    logic [EXP_W-1:0]    exp_b_eff;
    logic [FRAC_W-1:0]   frac_a;
    logic [FRAC_W-1:0]   frac_b;
    logic [MW-1:0]       mant_a;
    logic [MW-1:0]       mant_b;
    logic                a_nan;
    logic                a_inf;
    logic                b_nan;
    logic                b_inf;
    logic                b_larger;

    // stage-1 candidate values
    logic [MW-1:0]       c_mant_l;
    logic [MW-1:0]       c_mant_s;
    logic [EXP_W-1:0]    c_exp_l;
    logic [EXP_W-1:0]    c_exp_s;
    logic [EXP_W-1:0]    c_diff;
    logic                c_sign;
    logic                c_eff_sub;
    logic                c_nan;
    logic                c_inf;

    // stage-1 registers
    logic                s1_valid_q,   s1_valid_d;
    logic [MW-1:0]       s1_mant_l_q,  s1_mant_l_d;
    logic [MW-1:0]       s1_mant_s_q,  s1_mant_s_d;
    logic [EXP_W-1:0]    s1_exp_q,     s1_exp_d;
    logic [EXP_W-1:0]    s1_diff_q,    s1_diff_d;
    logic                s1_sign_q,    s1_sign_d;
    logic                s1_eff_sub_q, s1_eff_sub_d;
    logic                s1_swapped_q, s1_swapped_d;
    logic                s1_nan_q,     s1_nan_d;
    logic                s1_inf_q,     s1_inf_d;

    // stage-2 (output) registers
    logic                out_valid_q,   out_valid_d;
    logic [MW-1:0]       out_mant_l_q,  out_mant_l_d;
    logic [MW-1:0]       out_mant_s_q,  out_mant_s_d;
    logic [EXP_W-1:0]    out_exp_q,     out_exp_d;
    logic                out_sign_q,    out_sign_d;
    logic                out_eff_sub_q, out_eff_sub_d;
    logic                out_swapped_q, out_swapped_d;
    logic                out_nan_q,     out_nan_d;
    logic                out_inf_q,     out_inf_d;

    // alignment shifter
    logic [MW-1:0]       al_val;
    logic                al_sticky;
    logic [EXP_W-1:0]    al_diff_bits;
    logic                al_diff_big;
    logic [MW-1:0]       al_mant_s;

    logic                s1_adv;
    logic                in_fire;

    assign s1_adv   = !out_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s1_adv;
    assign in_fire  = in_valid && in_ready;

    assign sign_a     = in_a[W-1];
    assign sign_b_eff = in_b[W-1] ^ in_op;
    assign exp_a      = in_a[W-2 -: EXP_W];
    assign exp_b      = in_b[W-2 -: EXP_W];
    assign frac_a     = in_a[FRAC_W-1:0];
    assign frac_b     = in_b[FRAC_W-1:0];

    // Zero exponent encodes denormals/zero: no hidden bit, effective exponent of one.
    assign exp_a_eff = (exp_a == '0) ? EXP_ONE : exp_a;
    assign exp_b_eff = (exp_b == '0) ? EXP_ONE : exp_b;
    assign mant_a    = {1'b0, |exp_a, frac_a, 3'b000};
    assign mant_b    = {1'b0, |exp_b, frac_b, 3'b000};

    assign a_nan = (&exp_a) && (frac_a != '0);
    assign a_inf = (&exp_a) && (frac_a == '0);
    assign b_nan = (&exp_b) && (frac_b != '0);
    assign b_inf = (&exp_b) && (frac_b == '0);

    // Raw {exp, frac} ordering is magnitude ordering; equal magnitudes leave A as the larger.
    assign b_larger = {exp_b, frac_b} > {exp_a, frac_a};

    always_comb begin
        c_mant_l  = b_larger ? mant_b    : mant_a;
        c_mant_s  = b_larger ? mant_a    : mant_b;
        c_exp_l   = b_larger ? exp_b_eff : exp_a_eff;
        c_exp_s   = b_larger ? exp_a_eff : exp_b_eff;
        c_diff    = c_exp_l - c_exp_s;
        c_eff_sub = sign_a ^ sign_b_eff;
        c_nan     = a_nan || b_nan || (a_inf && b_inf && c_eff_sub);
        c_inf     = !c_nan && (a_inf || b_inf);
        if (c_inf) begin
            c_sign = a_inf ? sign_a : sign_b_eff;
        end else begin
            c_sign = b_larger ? sign_b_eff : sign_a;
        end
    end

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_mant_l_d  = s1_mant_l_q;
        s1_mant_s_d  = s1_mant_s_q;
        s1_exp_d     = s1_exp_q;
        s1_diff_d    = s1_diff_q;
        s1_sign_d    = s1_sign_q;
        s1_eff_sub_d = s1_eff_sub_q;
        s1_swapped_d = s1_swapped_q;
        s1_nan_d     = s1_nan_q;
        s1_inf_d     = s1_inf_q;
        if (in_ready) begin
            s1_valid_d = in_fire;
        end
        if (in_fire) begin
            s1_mant_l_d  = c_mant_l;
            s1_mant_s_d  = c_mant_s;
            s1_exp_d     = c_exp_l;
            s1_diff_d    = c_diff;
            s1_sign_d    = c_sign;
            s1_eff_sub_d = c_eff_sub;
            s1_swapped_d = b_larger;
            s1_nan_d     = c_nan;
            s1_inf_d     = c_inf;
        end
    end

    // Logarithmic right shifter; each stage ORs the bits it drops into the sticky bit.
    always_comb begin
        al_val       = s1_mant_s_q;
        al_sticky    = 1'b0;
        al_diff_bits = s1_diff_q;
        for (int k = 0; k < SH_BITS; k++) begin
            if (al_diff_bits[0]) begin
                al_sticky = al_sticky | (|(al_val & ~({MW{1'b1}} << (1 << k))));
                al_val    = al_val >> (1 << k);
            end
            al_diff_bits = al_diff_bits >> 1;
        end
        al_diff_big = {{(32-EXP_W){1'b0}}, s1_diff_q} >= MW;
        if (al_diff_big) begin
            al_mant_s = {{(MW-1){1'b0}}, |s1_mant_s_q};
        end else begin
            al_mant_s = {al_val[MW-1:1], al_val[0] | al_sticky};
        end
    end

    always_comb begin
        out_valid_d   = out_valid_q;
        out_mant_l_d  = out_mant_l_q;
        out_mant_s_d  = out_mant_s_q;
        out_exp_d     = out_exp_q;
        out_sign_d    = out_sign_q;
        out_eff_sub_d = out_eff_sub_q;
        out_swapped_d = out_swapped_q;
        out_nan_d     = out_nan_q;
        out_inf_d     = out_inf_q;
        if (s1_adv) begin
            out_valid_d = s1_valid_q;
        end
        if (s1_adv && s1_valid_q) begin
            out_mant_l_d  = s1_mant_l_q;
            out_mant_s_d  = al_mant_s;
            out_exp_d     = s1_exp_q;
            out_sign_d    = s1_sign_q;
            out_eff_sub_d = s1_eff_sub_q;
            out_swapped_d = s1_swapped_q;
            out_nan_d     = s1_nan_q;
            out_inf_d     = s1_inf_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q    <= 1'b0;
            s1_mant_l_q   <= '0;
            s1_mant_s_q   <= '0;
            s1_exp_q      <= '0;
            s1_diff_q     <= '0;
            s1_sign_q     <= 1'b0;
            s1_eff_sub_q  <= 1'b0;
            s1_swapped_q  <= 1'b0;
            s1_nan_q      <= 1'b0;
            s1_inf_q      <= 1'b0;
            out_valid_q   <= 1'b0;
            out_mant_l_q  <= '0;
            out_mant_s_q  <= '0;
            out_exp_q     <= '0;
            out_sign_q    <= 1'b0;
            out_eff_sub_q <= 1'b0;
            out_swapped_q <= 1'b0;
            out_nan_q     <= 1'b0;
            out_inf_q     <= 1'b0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_mant_l_q   <= s1_mant_l_d;
            s1_mant_s_q   <= s1_mant_s_d;
            s1_exp_q      <= s1_exp_d;
            s1_diff_q     <= s1_diff_d;
            s1_sign_q     <= s1_sign_d;
            s1_eff_sub_q  <= s1_eff_sub_d;
            s1_swapped_q  <= s1_swapped_d;
            s1_nan_q      <= s1_nan_d;
            s1_inf_q      <= s1_inf_d;
            out_valid_q   <= out_valid_d;
            out_mant_l_q  <= out_mant_l_d;
            out_mant_s_q  <= out_mant_s_d;
            out_exp_q     <= out_exp_d;
            out_sign_q    <= out_sign_d;
            out_eff_sub_q <= out_eff_sub_d;
            out_swapped_q <= out_swapped_d;
            out_nan_q     <= out_nan_d;
            out_inf_q     <= out_inf_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_mant_l  = out_mant_l_q;
    assign out_mant_s  = out_mant_s_q;
    assign out_exp     = out_exp_q;
    assign out_sign    = out_sign_q;
    assign out_eff_sub = out_eff_sub_q;
    assign out_swapped = out_swapped_q;
    assign out_nan     = out_nan_q;
    assign out_inf     = out_inf_q;

endmodule
